// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit : PC register and req/ack instruction fetch with decoded IR
// Rev 1.0
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ins_valid,
    input  logic        ins_done,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [15:0] imm,
    output logic [31:0] curPC,
    output logic [31:0] nextPC,
    output logic        halted,
    output logic        fetch_err
);

    localparam int c_CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FETCH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [31:0]         r_pc;
    logic [31:0]         r_ir;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_fetchErr;
    logic [31:0]         w_pc4;
    logic [31:0]         w_nextPc;
    logic                w_loadIr;
    logic                w_commit;
    logic                w_timeout;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_loadIr    = 1'b0;
        w_commit    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (imem_ack) begin
                    w_loadIr    = 1'b1;
                    w_stateNext = S_EXEC;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_stateNext = S_HALT;
                end
            end
            S_EXEC: begin
                // PCWre/PCSrc only matter on the completing edge
                if (ins_done) begin
                    if (PCWre) begin
                        w_commit    = 1'b1;
                        w_stateNext = S_FETCH;
                    end else begin
                        w_stateNext = S_HALT;
                    end
                end
            end
            S_HALT:  w_stateNext = S_HALT;
            default: w_stateNext = S_HALT;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_pc       <= RESET_PC;
            r_ir       <= 32'h0;
            r_cnt      <= '0;
            r_fetchErr <= 1'b0;
        end else begin
            if (w_loadIr) begin
                r_ir <= imem_rdata;
            end
            if (w_commit) begin
                r_pc <= w_nextPc;
            end
            if (w_timeout) begin
                r_fetchErr <= 1'b1;
            end
            if (r_state == S_FETCH && !imem_ack && !w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign w_pc4 = r_pc + 32'd4;

    always_comb begin
        w_nextPc = w_pc4;
        case (PCSrc)
            2'b01:   w_nextPc = {w_pc4[31:28], r_ir[25:0], 2'b00};
            2'b10:   w_nextPc = w_pc4 + {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
            default: w_nextPc = w_pc4;
        endcase
    end

    // Request is gated by Reset so it drops the instant reset asserts
    assign imem_req  = Reset && (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign ins_valid = (r_state == S_EXEC);
    assign halted    = (r_state == S_HALT);
    assign fetch_err = r_fetchErr;
    assign curPC     = r_pc;
    assign nextPC    = w_nextPc;

    assign op  = r_ir[31:26];
    assign rs  = r_ir[25:21];
    assign rt  = r_ir[20:16];
    assign rd  = r_ir[15:11];
    assign sa  = r_ir[10:6];
    assign imm = r_ir[15:0];

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch_unit : randomized scoreboard bench for pc_fetch_unit
// Rev 1.0
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ack, done, pcwre;
    logic [1:0]  pcsrc;
    logic [31:0] rdata;
    logic        req, valid, halted, ferr;
    logic [31:0] addr, curpc, nextpc;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;

    logic        ack2, done2, pcwre2;
    logic [1:0]  pcsrc2;
    logic [31:0] rdata2;
    logic        req2, valid2, halted2, ferr2;
    logic [31:0] addr2, curpc2, nextpc2;
    logic [5:0]  op2;
    logic [4:0]  rs2, rt2, rd2, sa2;
    logic [15:0] imm2;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) u_dut (
        .CLK(clk), .Reset(rst_n), .imem_req(req), .imem_addr(addr),
        .imem_ack(ack), .imem_rdata(rdata), .ins_valid(valid), .ins_done(done),
        .PCWre(pcwre), .PCSrc(pcsrc), .op(op), .rs(rs), .rt(rt), .rd(rd),
        .sa(sa), .imm(imm), .curPC(curpc), .nextPC(nextpc), .halted(halted),
        .fetch_err(ferr)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FETCH_TIMEOUT(1)) u_dut2 (
        .CLK(clk), .Reset(rst_n), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2), .ins_valid(valid2), .ins_done(done2),
        .PCWre(pcwre2), .PCSrc(pcsrc2), .op(op2), .rs(rs2), .rt(rt2), .rd(rd2),
        .sa(sa2), .imm(imm2), .curPC(curpc2), .nextPC(nextpc2), .halted(halted2),
        .fetch_err(ferr2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        int          lat;
    } ins_t;

    typedef struct {
        logic        err;
        logic [31:0] pc;
    } halt_t;

    ins_t        ins_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] next_q[$];
    halt_t       halt_q[$];

    logic [31:0] mPc;
    logic [31:0] mIr;

    // Next PC from the architectural rules, using plain integer arithmetic
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ir,
                                             input logic [1:0] src);
        logic [31:0] pc4;
        int          off;
        pc4 = pc + 32'd4;
        case (src)
            2'd1: return (pc4 & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
            2'd2: begin
                off = int'($signed(ir[15:0])) * 4;
                return pc4 + 32'(off);
            end
            default: return pc4;
        endcase
    endfunction

    // Monitor: pops expectations whenever the DUT presents something
    logic  prevReq = 1'b0, prevValid = 1'b0, prevHalt = 1'b0;
    int    reqCnt = 0;
    ins_t  cur;
    halt_t hexp;
    logic [31:0] nexp;

    initial begin
        cur = '{pc: 32'h0, ir: 32'h0, lat: 0};
        forever begin
            @(negedge clk);
            if (req) begin
                if (!prevReq) begin
                    reqCnt = 1;
                    if (addr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_fetch: addr %0h with none expected", addr);
                    end else begin
                        chk("fetch_addr", addr, addr_q.pop_front());
                    end
                end else begin
                    reqCnt++;
                end
            end
            if (valid && !prevValid) begin
                if (ins_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: curPC %0h with none expected", curpc);
                end else begin
                    cur = ins_q.pop_front();
                    chk("req_cycles", 64'(reqCnt), 64'(cur.lat));
                end
            end
            if (valid) begin
                chk("ir_op",   op,    (cur.ir >> 26) & 32'h3F);
                chk("ir_regs", {rs, rt, rd, sa}, (cur.ir >> 6) & 32'hF_FFFF);
                chk("ir_imm",  imm,   cur.ir & 32'hFFFF);
                chk("cur_pc",  curpc, cur.pc);
            end
            if (valid && done) begin
                if (next_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: nextPC %0h with none expected", nextpc);
                end else begin
                    nexp = next_q.pop_front();
                    chk("next_pc", nextpc, nexp);
                end
            end
            if (halted && !prevHalt) begin
                if (halt_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_halt: curPC %0h with none expected", curpc);
                end else begin
                    hexp = halt_q.pop_front();
                    chk("halt_err", ferr, hexp.err);
                    chk("halt_pc", curpc, hexp.pc);
                end
            end
            prevReq   = req;
            prevValid = valid;
            prevHalt  = halted;
        end
    end

    // Called at posedge+1 with the DUT in its first FETCH cycle
    task automatic do_fetch(input int lat, input logic [31:0] word);
        ins_q.push_back('{pc: mPc, ir: word, lat: lat});
        mIr = word;
        for (int i = 0; i < lat - 1; i++) begin
            ack = 1'b0;
            @(posedge clk); #1;
        end
        ack   = 1'b1;
        rdata = word;
        @(posedge clk); #1;
        ack   = 1'b0;
        rdata = $urandom;
    endtask

    // Called at posedge+1 with the DUT in its first EXEC cycle
    task automatic do_exec(input int dwell, input logic we, input logic [1:0] src);
        logic [31:0] nxt;
        for (int i = 0; i < dwell; i++) begin
            done  = 1'b0;
            ack   = 1'($urandom);
            rdata = $urandom;
            pcwre = 1'($urandom);
            pcsrc = 2'($urandom);
            @(posedge clk); #1;
        end
        ack   = 1'b0;
        done  = 1'b1;
        pcwre = we;
        pcsrc = src;
        nxt   = ref_next(mPc, mIr, src);
        next_q.push_back(nxt);
        if (we) begin
            mPc = nxt;
            addr_q.push_back(mPc);
        end else begin
            halt_q.push_back('{err: 1'b0, pc: mPc});
        end
        @(posedge clk); #1;
        done = 1'b0;
    endtask

    initial begin
        int  n;
        bit  seen;
        rst_n = 1'b0; ack = 1'b0; done = 1'b0; pcwre = 1'b0; pcsrc = 2'd0; rdata = 32'h0;
        ack2 = 1'b0; done2 = 1'b0; pcwre2 = 1'b0; pcsrc2 = 2'd0; rdata2 = 32'h0;
        mPc = 32'h0; mIr = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", req, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_ferr", ferr, 1'b0);
        chk("rst_pc", curpc, 32'h0);
        chk("rst_ir", {op, rs, rt, rd, sa, imm}, 64'h0);
        chk("rst_pc2", curpc2, 32'hFFFF_FFFC);

        addr_q.push_back(32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_fetch(2, 32'h0022_1800);
        do_exec(1, 1'b1, 2'b00);
        do_fetch(1, $urandom);
        do_exec(0, 1'b1, 2'b00);
        do_fetch(3, $urandom);
        do_exec(2, 1'b1, 2'b00);
        do_fetch(1, {6'h04, 5'd1, 5'd2, 16'h0004});
        do_exec(1, 1'b1, 2'b10);
        do_fetch(2, {6'h04, 5'd3, 5'd4, 16'hFFFE});
        do_exec(0, 1'b1, 2'b10);
        do_fetch(1, {6'h02, 26'h10});
        do_exec(1, 1'b1, 2'b01);

        for (int i = 0; i < 40; i++) begin
            do_fetch($urandom_range(1, 15), $urandom);
            do_exec($urandom_range(0, 3), 1'b1, 2'($urandom));
        end

        do_fetch(2, {6'h3F, 26'($urandom)});
        do_exec(1, 1'b0, 2'($urandom));
        for (int i = 0; i < 20; i++) begin
            ack   = 1'($urandom);
            rdata = $urandom;
            @(negedge clk);
            chk("halt_req", req, 1'b0);
            chk("halt_valid", valid, 1'b0);
            chk("halt_flag", halted, 1'b1);
            chk("halt_pc_hold", curpc, mPc);
            chk("halt_op_hold", op, 6'h3F);
            @(posedge clk); #1;
        end

        rst_n = 1'b0;
        ack   = 1'b1;
        rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst2_req", req, 1'b0);
        chk("rst2_ir", {op, rs, rt, rd, sa, imm}, 64'h0);
        chk("rst2_pc", curpc, 32'h0);
        chk("rst2_halted", halted, 1'b0);
        @(posedge clk); #1;
        ack = 1'b0;
        addr_q.push_back(32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_req", req, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        ack   = 1'b1;
        rdata = $urandom;
        #2;
        chk("async_req_drop", req, 1'b0);
        @(negedge clk);
        chk("rst3_ir", {op, rs, rt, rd, sa, imm}, 64'h0);
        @(posedge clk); #1;
        ack = 1'b0;

        halt_q.push_back('{err: 1'b1, pc: 32'h0});
        addr_q.push_back(32'h0);
        rst_n = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (halted) begin
                seen = 1'b1;
                break;
            end
            if (req) n++;
        end
        chk("timeout_seen", seen, 1'b1);
        chk("timeout_req_cycles", 64'(n), 64'd16);
        chk("timeout_ferr", ferr, 1'b1);
        chk("timeout_req_low", req, 1'b0);

        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        halt_q.push_back('{err: 1'b1, pc: 32'h0});
        addr_q.push_back(32'h0);
        rst_n  = 1'b1;
        ack2   = 1'b1;
        rdata2 = 32'h0;
        @(posedge clk); #1;
        ack2   = 1'b0;
        done2  = 1'b1;
        pcwre2 = 1'b1;
        pcsrc2 = 2'b00;
        @(negedge clk);
        chk("wrap_valid", valid2, 1'b1);
        chk("wrap_cur_pc", curpc2, 32'hFFFF_FFFC);
        chk("wrap_next_pc", nextpc2, 32'h0);
        @(posedge clk); #1;
        done2 = 1'b0;
        @(negedge clk);
        chk("wrap_req", req2, 1'b1);
        chk("wrap_addr", addr2, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_halted", halted2, 1'b1);
        chk("t1_ferr", ferr2, 1'b1);
        chk("t1_req_low", req2, 1'b0);

        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
        chk("ins_q_empty", 64'(ins_q.size()), 64'd0);
        chk("next_q_empty", 64'(next_q.size()), 64'd0);
        chk("halt_q_empty", 64'(halt_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
